// File: rtl/wght_upd.sv
`default_nettype none
// ============================================================================
// Module   : wght_upd
// Purpose  : Weight update sequencer. After a batch it walks every weight
//            address, reads the stored weight, subtracts lr * gradient in
//            WIDTH/FRAC fixed point with saturation, writes the result back,
//            then pulses a clear to the accumulator bank and signals done.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_start         - start request (accepted only when idle)
//            i_lr            - learning rate, captured at start
//            i_grad          - accumulator value selected by o_addr (comb)
//            i_w             - weight read data, one cycle after o_addr
//            o_addr          - weight/accumulator index
//            o_w, o_we       - weight write data / write enable
//            o_acc_clr       - one-cycle clear pulse to accumulator bank
//            o_busy, o_done  - not idle / one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module wght_upd #(
   parameter int WIDTH = 24,
   parameter int FRAC  = 20,
   parameter int NW    = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_lr,
   input  logic [WIDTH-1:0] i_grad,
   input  logic [WIDTH-1:0] i_w,
   output logic [AW-1:0]    o_addr,
   output logic [WIDTH-1:0] o_w,
   output logic             o_we,
   output logic             o_acc_clr,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_CLR  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int            PW     = 2 * WIDTH;
   localparam logic [AW-1:0] K_LAST = AW'(NW - 1);

   localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       state_q, state_d;
   logic [AW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] lr_q, lr_d;

   // ------------------------------------------------------------------
   // Update arithmetic
   // ------------------------------------------------------------------
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shf;
   logic [PW-WIDTH:0]    shf_hi;
   logic [WIDTH-1:0]     d_sat;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     upd;

   always_comb begin
      prod   = $signed({{WIDTH{lr_q[WIDTH-1]}}, lr_q}) *
               $signed({{WIDTH{i_grad[WIDTH-1]}}, i_grad});
      // Arithmetic shift gives floor for negative products.
      shf    = prod >>> FRAC;
      shf_hi = shf[PW-1:WIDTH-1];
      // The scaled product fits in WIDTH bits only if every bit above the
      // WIDTH-bit sign bit repeats it.
      if ((&shf_hi) || !(|shf_hi)) begin
         d_sat = shf[WIDTH-1:0];
      end else if (shf[PW-1]) begin
         d_sat = C_MIN;
      end else begin
         d_sat = C_MAX;
      end
      diff = {i_w[WIDTH-1], i_w} - {d_sat[WIDTH-1], d_sat};
      // Overflow when the extra sign bit disagrees with the WIDTH-bit sign.
      if (diff[WIDTH] != diff[WIDTH-1]) begin
         upd = diff[WIDTH] ? C_MIN : C_MAX;
      end else begin
         upd = diff[WIDTH-1:0];
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         lr_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         lr_q    <= lr_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      lr_d    = lr_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               lr_d    = i_lr;
               k_d     = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            if (k_q == K_LAST) begin
               state_d = S_CLR;
            end else begin
               k_d     = k_q + AW'(1);
               state_d = S_RD;
            end
         end
         S_CLR: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin
      // k only moves at start and in WR, so it also serves as the held
      // address outside RD/WR.
      o_addr    = k_q;
      o_we      = (state_q == S_WR);
      o_w       = (state_q == S_WR) ? upd : '0;
      o_acc_clr = (state_q == S_CLR);
      o_busy    = (state_q != S_IDLE);
      o_done    = (state_q == S_DONE);
   end

endmodule
`default_nettype wire
